// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift/rotate register with registered serial-out and a
// burst engine that repeats a latched operation cnt times, flagging busy/done.
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] pdata,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_LOAD  = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_SHR   = 3'b011;
  localparam logic [2:0] M_ROL   = 3'b100;
  localparam logic [2:0] M_ROR   = 3'b101;
  localparam logic [2:0] M_ASR   = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  logic [2:0]       lmode;
  logic [CNT_W-1:0] count;
  logic [2:0]       op;
  logic [WIDTH-1:0] q_nxt;
  logic             sout_nxt;

  // During a burst the latched mode drives the datapath; idle uses the live mode.
  assign op = busy ? lmode : mode;

  always_comb begin
    q_nxt    = q;
    sout_nxt = sout;
    case (op)
      M_HOLD:  q_nxt = q;
      M_LOAD:  q_nxt = pdata;
      M_SHL: begin
        q_nxt    = {q[WIDTH-2:0], sin};
        sout_nxt = q[WIDTH-1];
      end
      M_SHR: begin
        q_nxt    = {sin, q[WIDTH-1:1]};
        sout_nxt = q[0];
      end
      M_ROL: begin
        q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
        sout_nxt = q[WIDTH-1];
      end
      M_ROR: begin
        q_nxt    = {q[0], q[WIDTH-1:1]};
        sout_nxt = q[0];
      end
      M_ASR: begin
        q_nxt    = {q[WIDTH-1], q[WIDTH-1:1]};
        sout_nxt = q[0];
      end
      M_CLEAR: q_nxt = '0;
      default: q_nxt = q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      sout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      count <= '0;
      lmode <= M_HOLD;
    end else begin
      done <= 1'b0;
      if (busy) begin
        q     <= q_nxt;
        sout  <= sout_nxt;
        count <= count - 1'b1;
        if (count == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end else if (start) begin
        // Accept edge only latches; q is untouched and en is ignored.
        lmode <= mode;
        count <= cnt;
        if (cnt == '0) begin
          done <= 1'b1;
        end else begin
          busy <= 1'b1;
        end
      end else if (en) begin
        q    <= q_nxt;
        sout <= sout_nxt;
      end
    end
  end

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register: directed vector table, mid-burst reset
// sequence, and randomized traffic against an arithmetic reference model.
module tb_universal_shift_register;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] mode;
  logic       sin;
  logic [7:0] pdata;
  logic       start;
  logic [3:0] cnt;
  logic [7:0] q;
  logic       sout;
  logic       busy;
  logic       done;

  universal_shift_register #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sin(sin), .pdata(pdata),
    .start(start), .cnt(cnt), .q(q), .sout(sout), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: plain integers, shifts done with * and / arithmetic.
  int mq, msout, mbusy, mdone, rem, lmode;

  typedef struct {
    logic       en;
    logic [2:0] mode;
    logic       sin;
    logic [7:0] pdata;
    logic       start;
    logic [3:0] cnt;
    logic [7:0] q;
    logic       sout;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq = 0; msout = 0; mbusy = 0; mdone = 0; rem = 0; lmode = 0;
  endtask

  task automatic model_apply(input int op, input int s, input int pd);
    int old;
    old = mq;
    case (op)
      1: mq = pd;
      2: begin msout = old / 128; mq = (old * 2) % 256 + s; end
      3: begin msout = old % 2;   mq = old / 2 + s * 128; end
      4: begin msout = old / 128; mq = (old * 2) % 256 + old / 128; end
      5: begin msout = old % 2;   mq = old / 2 + (old % 2) * 128; end
      6: begin msout = old % 2;   mq = old / 2 + (old / 128) * 128; end
      7: mq = 0;
      default: ;
    endcase
  endtask

  task automatic model_step(input int e, input int m, input int s, input int pd,
                            input int st, input int c);
    mdone = 0;
    if (mbusy != 0) begin
      model_apply(lmode, s, pd);
      rem = rem - 1;
      if (rem == 0) begin
        mbusy = 0;
        mdone = 1;
      end
    end else if (st != 0) begin
      lmode = m;
      rem   = c;
      if (c == 0) mdone = 1;
      else        mbusy = 1;
    end else if (e != 0) begin
      model_apply(m, s, pd);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, advance the model, sample 1ns after the rising edge.
  task automatic step(input logic e, input logic [2:0] m, input logic s,
                      input logic [7:0] pd, input logic st, input logic [3:0] c);
    @(negedge clk);
    en = e; mode = m; sin = s; pdata = pd; start = st; cnt = c;
    model_step(int'(e), int'(m), int'(s), int'(pd), int'(st), int'(c));
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_model(input string tag);
    check({tag, ".q"},    int'(q),    mq);
    check({tag, ".sout"}, int'(sout), msout);
    check({tag, ".busy"}, int'(busy), mbusy);
    check({tag, ".done"}, int'(done), mdone);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 0; mode = 0; sin = 0; pdata = 0; start = 0; cnt = 0;
    model_reset();
    #12;
    check("reset.q", int'(q), 0);
    check("reset.sout", int'(sout), 0);
    check("reset.busy", int'(busy), 0);
    check("reset.done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    //            en mode   sin pdata  st cnt   q     sout busy done
    vecs.push_back('{1, 3'd1, 0, 8'hA5, 0, 4'd0, 8'hA5, 0, 0, 0}); // load
    vecs.push_back('{1, 3'd2, 1, 8'h00, 0, 4'd0, 8'h4B, 1, 0, 0}); // SHL sin=1
    vecs.push_back('{0, 3'd2, 1, 8'h00, 0, 4'd0, 8'h4B, 1, 0, 0}); // en=0 holds
    vecs.push_back('{1, 3'd1, 0, 8'h81, 0, 4'd0, 8'h81, 1, 0, 0});
    vecs.push_back('{1, 3'd5, 0, 8'h00, 1, 4'd3, 8'h81, 1, 1, 0}); // ROR burst accept
    vecs.push_back('{0, 3'd0, 0, 8'h00, 1, 4'd7, 8'hC0, 1, 1, 0}); // start mid-burst ignored
    vecs.push_back('{1, 3'd7, 0, 8'h00, 0, 4'd0, 8'h60, 0, 1, 0});
    vecs.push_back('{0, 3'd0, 0, 8'h00, 0, 4'd0, 8'h30, 0, 0, 1}); // last op, done
    vecs.push_back('{1, 3'd1, 0, 8'h90, 0, 4'd0, 8'h90, 0, 0, 0});
    vecs.push_back('{1, 3'd6, 0, 8'h00, 0, 4'd0, 8'hC8, 0, 0, 0}); // ASR
    vecs.push_back('{1, 3'd6, 0, 8'h00, 0, 4'd0, 8'hE4, 0, 0, 0});
    vecs.push_back('{1, 3'd7, 0, 8'h00, 0, 4'd0, 8'h00, 0, 0, 0}); // clear
    vecs.push_back('{1, 3'd3, 0, 8'h00, 1, 4'd0, 8'h00, 0, 0, 1}); // zero-length burst
    vecs.push_back('{0, 3'd2, 1, 8'h00, 1, 4'd1, 8'h00, 0, 1, 0}); // start during done
    vecs.push_back('{0, 3'd0, 1, 8'h00, 0, 4'd0, 8'h01, 0, 0, 1});
    vecs.push_back('{0, 3'd0, 0, 8'h00, 0, 4'd0, 8'h01, 0, 0, 0});
    vecs.push_back('{1, 3'd1, 0, 8'hFF, 0, 4'd0, 8'hFF, 0, 0, 0});
    vecs.push_back('{1, 3'd2, 1, 8'h00, 0, 4'd0, 8'hFF, 1, 0, 0});
    vecs.push_back('{1, 3'd7, 0, 8'h00, 0, 4'd0, 8'h00, 1, 0, 0}); // clear keeps sout
    vecs.push_back('{1, 3'd3, 1, 8'h00, 0, 4'd0, 8'h80, 0, 0, 0}); // SHR sin=1
    vecs.push_back('{1, 3'd1, 0, 8'h11, 1, 4'd2, 8'h80, 0, 1, 0}); // load burst
    vecs.push_back('{0, 3'd0, 0, 8'h22, 0, 4'd0, 8'h22, 0, 1, 0}); // pdata resampled
    vecs.push_back('{0, 3'd0, 0, 8'h33, 0, 4'd0, 8'h33, 0, 0, 1});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].mode, vecs[i].sin, vecs[i].pdata, vecs[i].start, vecs[i].cnt);
      check($sformatf("vec%0d.q", i),    int'(q),    int'(vecs[i].q));
      check($sformatf("vec%0d.sout", i), int'(sout), int'(vecs[i].sout));
      check($sformatf("vec%0d.busy", i), int'(busy), int'(vecs[i].busy));
      check($sformatf("vec%0d.done", i), int'(done), int'(vecs[i].done));
    end

    // Asynchronous reset in the middle of a 5-op SHL burst.
    step(1, 3'd1, 0, 8'h3C, 0, 4'd0);
    cmp_model("rst_pre");
    step(0, 3'd2, 1, 8'h00, 1, 4'd5);
    cmp_model("rst_acc");
    step(0, 3'd0, 1, 8'h00, 0, 4'd0);
    step(0, 3'd0, 1, 8'h00, 0, 4'd0);
    cmp_model("rst_ops");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst.q", int'(q), 0);
    check("midrst.sout", int'(sout), 0);
    check("midrst.busy", int'(busy), 0);
    check("midrst.done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(0, 3'd0, 0, 8'h00, 0, 4'd0);
      cmp_model($sformatf("postrst%0d", i));
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           8'($urandom), 1'($urandom_range(0, 5) == 0), 4'($urandom_range(0, 4)));
      cmp_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
